// File: rtl/ex_tracker_pkg.sv
// Shared trace types for the ID->EX->WB trace hand-off and the EX tracker state encoding.
package ex_tracker_pkg;

   localparam int unsigned TRACE_ADDR_W = 32;
   localparam int unsigned TRACE_DATA_W = 32;

   typedef struct packed {
      logic [31:0] time_start;
      logic [31:0] time_end;
   } ex_data_t;

   typedef struct packed {
      logic [TRACE_ADDR_W-1:0] pc;
      logic [31:0]             instr;
      logic [TRACE_ADDR_W-1:0] mem_addr;
      logic [TRACE_DATA_W-1:0] mem_data;
      logic                    pass_through;
      ex_data_t                ex_data;
   } trace_output;

   typedef enum logic [2:0] {
      IDLE,
      EXEC_START,
      EXEC_END,
      PASS,
      EMIT
   } ex_state_t;

endpackage

// File: rtl/ex_tracker_trace_fifo.sv
// Synchronous FIFO of trace_output elements; pointers wrap modulo FIFO_DEPTH.
module ex_tracker_trace_fifo
   import ex_tracker_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  trace_output                  data_i,
   output trace_output                  data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(FIFO_DEPTH):0]  count_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   trace_output   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A pop frees the head slot in the same cycle, so a push at full is accepted alongside it.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/ex_tracker.sv
// EX-stage trace tracker: buffers ID hand-offs, stamps EX start/end times, forwards to WB.
module ex_tracker
   import ex_tracker_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] counter,
   input  logic        id_data_ready,
   input  trace_output id_data_in,
   input  logic        is_executing,
   output trace_output ex_data_o,
   output logic        ex_data_ready,
   output logic        overflow
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   if (ADDR_WIDTH != TRACE_ADDR_W || DATA_WIDTH != TRACE_DATA_W) begin : g_width_check
      $error("ex_tracker: ADDR_WIDTH/DATA_WIDTH must match the trace_output layout");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("ex_tracker: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   ex_state_t     state_q, state_d;
   trace_output   cur_q, cur_d;
   trace_output   out_q, out_d;
   logic          rdy_q, rdy_d;
   logic          id_ready_q;
   logic          ovf_q;
   logic          id_rise;
   logic          fifo_pop, fifo_full, fifo_empty;
   trace_output   fifo_rdata;
   logic [CW-1:0] fifo_count;

   assign id_rise = id_data_ready & ~id_ready_q;

   ex_tracker_trace_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (id_rise),
      .pop_i   (fifo_pop),
      .data_i  (id_data_in),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      out_d    = out_q;
      rdy_d    = rdy_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cur_d    = fifo_rdata;
               rdy_d    = 1'b0;
               state_d  = fifo_rdata.pass_through ? PASS : EXEC_START;
            end
         end
         EXEC_START: begin
            if (is_executing) begin
               cur_d.ex_data.time_start = counter;
               state_d = EXEC_END;
            end
         end
         EXEC_END: begin
            if (!is_executing) begin
               cur_d.ex_data.time_end = counter;
               state_d = EMIT;
            end
         end
         PASS: begin
            cur_d.ex_data = '0;
            state_d       = EMIT;
         end
         EMIT: begin
            out_d   = cur_q;
            rdy_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         out_q      <= '0;
         rdy_q      <= 1'b0;
         id_ready_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         out_q      <= out_d;
         rdy_q      <= rdy_d;
         id_ready_q <= id_data_ready;
         ovf_q      <= ovf_q | (id_rise & fifo_full & ~fifo_pop);
      end
   end

   assign ex_data_o     = out_q;
   assign ex_data_ready = rdy_q;
   assign overflow      = ovf_q;

   a_full_matches_count: assert property (@(posedge clk) disable iff (!rst)
      fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ex_tracker.sv
// Randomized self-checking bench for ex_tracker against a behavioural model of the hand-off.
module tb_ex_tracker;
   import ex_tracker_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] counter = '0;
   logic        id_data_ready = 1'b0;
   trace_output id_data_in = '0;
   logic        is_executing = 1'b0;
   trace_output ex_data_o;
   logic        ex_data_ready;
   logic        overflow;

   logic        cnt_load = 1'b0;
   logic [31:0] cnt_val = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_rdy = 1'b0;

   trace_output got_q[$];
   int          rise_q[$];
   trace_output exp_q[$];
   trace_output pend_q[$];

   ex_tracker #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .counter       (counter),
      .id_data_ready (id_data_ready),
      .id_data_in    (id_data_in),
      .is_executing  (is_executing),
      .ex_data_o     (ex_data_o),
      .ex_data_ready (ex_data_ready),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      counter <= cnt_load ? cnt_val : counter + 32'd1;
      cyc     <= cyc + 1;
   end

   // Every 0->1 edge of ex_data_ready delivers one element downstream.
   always @(posedge clk) begin
      #1;
      if (ex_data_ready && !prev_rdy) begin
         got_q.push_back(ex_data_o);
         rise_q.push_back(cyc);
      end
      prev_rdy = ex_data_ready;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_q();
      got_q.delete();
      rise_q.delete();
      exp_q.delete();
      pend_q.delete();
   endtask

   function automatic trace_output rand_elem(input logic pass);
      trace_output e;
      e.pc                 = $urandom;
      e.instr              = $urandom;
      e.mem_addr           = $urandom;
      e.mem_data           = $urandom;
      e.pass_through       = pass;
      e.ex_data.time_start = $urandom;
      e.ex_data.time_end   = $urandom;
      return e;
   endfunction

   task automatic send(input trace_output e, output int push_cyc);
      @(negedge clk);
      id_data_in    = e;
      id_data_ready = 1'b1;
      push_cyc      = cyc + 1;
      @(negedge clk);
      id_data_ready = 1'b0;
   endtask

   // Call only once the element is (or will next be) the one awaiting execution.
   task automatic exec_one(input trace_output e, output trace_output x);
      x = e;
      repeat (1 + $urandom_range(0, 2)) tick();
      is_executing = 1'b1;
      x.ex_data.time_start = counter;
      repeat ($urandom_range(1, 4)) tick();
      is_executing = 1'b0;
      x.ex_data.time_end = counter;
   endtask

   task automatic wait_out(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic drain(output bit ok);
      trace_output e, x;
      ok = 1'b1;
      while (pend_q.size() > 0 && ok) begin
         e = pend_q.pop_front();
         if (e.pass_through) begin
            x = e;
            x.ex_data = '0;
         end else begin
            exec_one(e, x);
         end
         exp_q.push_back(x);
         wait_out(exp_q.size(), ok);
      end
   endtask

   task automatic test_reset();
      trace_output a, x;
      int pc, n0;
      bit ok;
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (ex_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ex_data_ready); end
      checks++;
      if (ex_data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", ex_data_o); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      rst = 1'b1;
      clear_q();
      a = rand_elem(1'b1);
      a.instr = 32'h0000_0013;
      send(a, pc);
      wait_out(1, ok);
      send(rand_elem(1'b0), pc);
      tick();
      is_executing = 1'b1;
      repeat (3) tick();
      send(rand_elem(1'b1), pc);
      send(rand_elem(1'b0), pc);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ex_data_o !== '0) begin errors++; $display("FAIL midreset_data got=%h exp=0", ex_data_o); end
      checks++;
      if (ex_data_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got=%b exp=0", ex_data_ready); end
      @(negedge clk);
      rst = 1'b1;
      is_executing = 1'b0;
      n0 = got_q.size();
      repeat (20) tick();
      checks++;
      if (got_q.size() != n0) begin errors++; $display("FAIL reset_flush got=%0d exp=%0d", got_q.size(), n0); end
      a = rand_elem(1'b1);
      send(a, pc);
      wait_out(n0 + 1, ok);
      x = a;
      x.ex_data = '0;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL reset_idle_timeout got=no_edge exp=edge");
      end else if (got_q[n0] !== x || rise_q[n0] - pc != 3) begin
         errors++; $display("FAIL reset_idle got=%h lat=%0d exp=%h lat=3", got_q[n0], rise_q[n0] - pc, x);
      end
   endtask

   task automatic test_basic();
      trace_output e, x;
      int pc;
      bit ok;
      clear_q();
      @(negedge clk);
      cnt_load = 1'b1;
      cnt_val  = 32'd0;
      tick();
      cnt_load = 1'b0;
      e = rand_elem(1'b0);
      e.instr = 32'h00A0_0093;
      send(e, pc);
      for (int i = 0; i < 30 && counter != 32'd10; i++) tick();
      is_executing = 1'b1;
      for (int i = 0; i < 30 && counter != 32'd13; i++) tick();
      is_executing = 1'b0;
      x = e;
      x.ex_data.time_start = 32'd10;
      x.ex_data.time_end   = 32'd13;
      wait_out(1, ok);
      repeat (10) tick();
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL basic_edges got=%0d exp=1", got_q.size()); end
      checks++;
      if (ok && got_q[0] !== x) begin errors++; $display("FAIL basic_elem got=%h exp=%h", got_q[0], x); end
      else if (!ok) begin errors++; $display("FAIL basic_timeout got=no_edge exp=edge"); end
   endtask

   task automatic test_pass();
      trace_output e, x;
      int pc;
      for (int it = 0; it < 4; it++) begin
         clear_q();
         e = rand_elem(1'b1);
         e.ex_data.time_start = 32'h0000_FFFF;
         e.ex_data.time_end   = 32'h0000_FFFF;
         is_executing = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         send(e, pc);
         for (int k = 0; k < 20 && got_q.size() == 0; k++) begin
            if (it != 0) is_executing = 1'($urandom_range(0, 1));
            tick();
         end
         is_executing = 1'b0;
         x = e;
         x.ex_data = '0;
         checks++;
         if (got_q.size() == 0) begin
            errors++; $display("FAIL pass%0d_timeout got=no_edge exp=edge", it);
         end else if (got_q[0] !== x || rise_q[0] - pc != 3) begin
            errors++; $display("FAIL pass%0d got=%h lat=%0d exp=%h lat=3", it, got_q[0], rise_q[0] - pc, x);
         end
      end
   endtask

   task automatic test_back_to_back();
      trace_output e, x1;
      int pc;
      bit ok;
      clear_q();
      e = rand_elem(1'b0);
      send(e, pc);
      tick();
      is_executing = 1'b1;
      x1 = e;
      x1.ex_data.time_start = counter;
      tick();
      for (int i = 0; i < 3; i++) begin
         e = rand_elem(1'($urandom_range(0, 1)));
         pend_q.push_back(e);
         send(e, pc);
      end
      is_executing = 1'b0;
      x1.ex_data.time_end = counter;
      exp_q.push_back(x1);
      wait_out(1, ok);
      if (ok) drain(ok);
      repeat (10) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout got=no_edge exp=edge"); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_elem%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_overflow();
      trace_output e, x1;
      int pc;
      bit ok;
      clear_q();
      e = rand_elem(1'b0);
      send(e, pc);
      tick();
      is_executing = 1'b1;
      x1 = e;
      x1.ex_data.time_start = counter;
      for (int i = 0; i < 4; i++) begin
         e = rand_elem(1'($urandom_range(0, 1)));
         pend_q.push_back(e);
         send(e, pc);
      end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_drop got=%b exp=0", overflow); end
      send(rand_elem(1'b1), pc);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      repeat (3) tick();
      is_executing = 1'b0;
      x1.ex_data.time_end = counter;
      exp_q.push_back(x1);
      wait_out(1, ok);
      if (ok) drain(ok);
      repeat (15) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_timeout got=no_edge exp=edge"); end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      checks++;
      if (got_q.size() != 5) begin errors++; $display("FAIL ovf_count got=%0d exp=5", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_elem%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
   endtask

   task automatic test_full_push_pop();
      trace_output e, x1;
      int pc;
      bit ok;
      clear_q();
      e = rand_elem(1'b0);
      send(e, pc);
      tick();
      is_executing = 1'b1;
      x1 = e;
      x1.ex_data.time_start = counter;
      for (int i = 0; i < 4; i++) begin
         e = rand_elem(1'($urandom_range(0, 1)));
         pend_q.push_back(e);
         send(e, pc);
      end
      is_executing = 1'b0;
      x1.ex_data.time_end = counter;
      exp_q.push_back(x1);
      // Lands exactly on the edge where the full FIFO pops its head.
      tick();
      e = rand_elem(1'($urandom_range(0, 1)));
      pend_q.push_back(e);
      send(e, pc);
      wait_out(1, ok);
      if (ok) drain(ok);
      repeat (15) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL fullpp_timeout got=no_edge exp=edge"); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got=%b exp=0", overflow); end
      checks++;
      if (got_q.size() != 6) begin errors++; $display("FAIL fullpp_count got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpp_elem%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_level_hold();
      trace_output e, x;
      clear_q();
      e = rand_elem(1'b1);
      @(negedge clk);
      id_data_in    = e;
      id_data_ready = 1'b1;
      repeat (20) tick();
      id_data_ready = 1'b0;
      repeat (20) tick();
      x = e;
      x.ex_data = '0;
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL level_count got=%0d exp=1", got_q.size()); end
      else begin
         checks++;
         if (got_q[0] !== x) begin errors++; $display("FAIL level_elem got=%h exp=%h", got_q[0], x); end
      end
   endtask

   task automatic test_random();
      trace_output e, x;
      int pc;
      bit ok;
      bit pass;
      clear_q();
      ok = 1'b1;
      for (int i = 0; i < 40 && ok; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            cnt_load = 1'b1;
            cnt_val  = 32'hFFFF_FFFE - $urandom_range(0, 3);
            tick();
            cnt_load = 1'b0;
         end
         pass = ($urandom_range(0, 3) == 0);
         e = rand_elem(pass);
         send(e, pc);
         if (pass) begin
            x = e;
            x.ex_data = '0;
         end else begin
            exec_one(e, x);
         end
         exp_q.push_back(x);
         wait_out(exp_q.size(), ok);
         if (ok && pass) begin
            checks++;
            if (rise_q[rise_q.size() - 1] - pc != 3) begin
               errors++; $display("FAIL rand%0d_pass_latency got=%0d exp=3", i, rise_q[rise_q.size() - 1] - pc);
            end
         end
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (10) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout got=no_edge exp=edge"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_elem%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pass();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_level_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
